// File: rtl/branch_target_predictor_if.sv
// Lookup/update/flush bus between the IF and resolve stages and the BTB.
// Master drives the requests; the slave (BTB) returns combinational predictions and counters.
interface branch_target_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] lookup_pc_i;
  logic              hit_o;
  logic              predict_taken_o;
  logic [ADDR_W-1:0] predict_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_taken_i;
  logic [ADDR_W-1:0] upd_pred_target_i;
  logic              flush_i;
  logic              mispredict_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [31:0]       upd_cnt_o;
  logic [31:0]       mispred_cnt_o;

  modport master (
    output lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, flush_i,
    input  hit_o, predict_taken_o, predict_target_o, mispredict_o,
           redirect_pc_o, upd_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, flush_i,
    output hit_o, predict_taken_o, predict_target_o, mispredict_o,
           redirect_pc_o, upd_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; 0-cycle lookup, update/flush at clk_i edge, no backpressure.
// BTB_PERF_CNT_EN adds saturating update/mispredict counters (ports read 0 otherwise).
module branch_target_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16
) (
  input logic                       clk_i,
  input logic                       rst_i,
  branch_target_predictor_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic               w_lk_taken;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic               w_mispredict;

  assign w_lk_idx   = bus.lookup_pc_i[IDX_W+1:2];
  assign w_lk_tag   = bus.lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_cnt[w_lk_idx][1];

  assign bus.hit_o            = w_lk_hit;
  assign bus.predict_taken_o  = w_lk_taken;
  assign bus.predict_target_o = w_lk_taken ? r_target[w_lk_idx]
                                           : bus.lookup_pc_i + ADDR_W'(4);

  assign w_upd_idx = bus.upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = bus.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  assign w_mispredict = bus.upd_valid_i &&
                        ((bus.upd_taken_i != bus.upd_pred_taken_i) ||
                         (bus.upd_taken_i && (bus.upd_target_i != bus.upd_pred_target_i)));

  assign bus.mispredict_o  = w_mispredict;
  assign bus.redirect_pc_o = bus.upd_taken_i ? bus.upd_target_i
                                             : bus.upd_pc_i + ADDR_W'(4);

  // Flush takes priority over a coincident update, which is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= 2'b01;
      end
    end else if (bus.flush_i) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= 2'b01;
      end
    end else if (bus.upd_valid_i) begin
      if (w_upd_hit) begin
        if (bus.upd_taken_i) begin
          if (r_cnt[w_upd_idx] != 2'b11) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + 2'b01;
          r_target[w_upd_idx] <= bus.upd_target_i;
        end else if (r_cnt[w_upd_idx] != 2'b00) begin
          r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken_i) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bus.upd_target_i;
        r_cnt[w_upd_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] r_upd_cnt;
  logic [31:0] r_mis_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_upd_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (!bus.flush_i) begin
      if (bus.upd_valid_i && (r_upd_cnt != 32'hFFFF_FFFF)) r_upd_cnt <= r_upd_cnt + 32'd1;
      if (w_mispredict && (r_mis_cnt != 32'hFFFF_FFFF))    r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign bus.upd_cnt_o     = r_upd_cnt;
  assign bus.mispred_cnt_o = r_mis_cnt;
`else
  assign bus.upd_cnt_o     = '0;
  assign bus.mispred_cnt_o = '0;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed plus randomized bench for branch_target_predictor against an array-based BTB model.
module tb_branch_target_predictor;
  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  branch_target_predictor_if #(.ADDR_W(ADDR_W)) bus();

  branch_target_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: confidence kept as an integer 0..3, clamped arithmetically
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_conf  [ENTRIES];
  longint      m_upds;
  longint      m_miss;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_conf[i] = 1;
    end
    m_upds = 0;
    m_miss = 0;
  endtask

  function automatic logic [63:0] perf_exp(input longint v);
`ifdef BTB_PERF_CNT_EN
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(v);
`else
    return (v < 0) ? 64'd1 : 64'd0;
`endif
  endfunction

  // Drive one cycle of inputs, check the combinational response, clock, then advance the model.
  task automatic apply(input logic [31:0] lpc, input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input bit upt, input logic [31:0] uptg, input bit fl);
    int  li, ui;
    bit  e_hit, e_tk, e_mis, u_hit;
    logic [31:0] e_tgt, e_redir;
    bus.lookup_pc_i = lpc;       bus.upd_valid_i = uv;       bus.upd_pc_i = upc;
    bus.upd_taken_i = ut;        bus.upd_target_i = utg;     bus.upd_pred_taken_i = upt;
    bus.upd_pred_target_i = uptg; bus.flush_i = fl;
    #1;
    li    = idx_of(lpc);
    e_hit = m_valid[li] && (m_tag[li] == tag_of(lpc));
    e_tk  = e_hit && (m_conf[li] >= 2);
    e_tgt = e_tk ? m_tgt[li] : lpc + 32'd4;
    e_mis = uv && ((ut != upt) || (ut && (utg != uptg)));
    e_redir = ut ? utg : upc + 32'd4;
    check_eq("hit", 64'(bus.hit_o), 64'(e_hit));
    check_eq("taken", 64'(bus.predict_taken_o), 64'(e_tk));
    check_eq("target", 64'(bus.predict_target_o), 64'(e_tgt));
    check_eq("mispredict", 64'(bus.mispredict_o), 64'(e_mis));
    if (e_mis) check_eq("redirect", 64'(bus.redirect_pc_o), 64'(e_redir));
    check_eq("upd_cnt", 64'(bus.upd_cnt_o), perf_exp(m_upds));
    check_eq("mispred_cnt", 64'(bus.mispred_cnt_o), perf_exp(m_miss));
    @(posedge clk_i);
    if (fl) begin
      for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 0; m_conf[i] = 1; end
    end else begin
      if (uv) m_upds++;
      if (e_mis) m_miss++;
      if (uv) begin
        ui    = idx_of(upc);
        u_hit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
        if (u_hit && ut) begin
          m_conf[ui] = (m_conf[ui] + 1 > 3) ? 3 : m_conf[ui] + 1;
          m_tgt[ui]  = utg;
        end else if (u_hit) begin
          m_conf[ui] = (m_conf[ui] - 1 < 0) ? 0 : m_conf[ui] - 1;
        end else if (ut) begin
          m_valid[ui] = 1; m_tag[ui] = tag_of(upc); m_tgt[ui] = utg; m_conf[ui] = 2;
        end
      end
    end
    #1;
  endtask

  task automatic lookup(input logic [31:0] lpc);
    apply(lpc, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 31) == 0) p = 32'hFFFF_FFFC;
    return p;
  endfunction

  initial begin
    logic [31:0] upc, utg, uptg;
    bit ut, upt;
    bus.lookup_pc_i = 32'h40; bus.upd_valid_i = 0; bus.upd_pc_i = 0; bus.upd_taken_i = 0;
    bus.upd_target_i = 0; bus.upd_pred_taken_i = 0; bus.upd_pred_target_i = 0; bus.flush_i = 0;
    model_reset();
    #12;
    check_eq("rst_hit", 64'(bus.hit_o), 64'd0);
    check_eq("rst_target", 64'(bus.predict_target_o), 64'h44);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;

    // allocate, then train down past the taken threshold
    lookup(32'h40);
    apply(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
    lookup(32'h40);
    repeat (3) apply(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0);
    lookup(32'h40);
    apply(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
    lookup(32'h40);
    // alias at the same index, then same-cycle update without bypass
    lookup(32'h80);
    apply(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84, 0);
    lookup(32'h80);
    lookup(32'h40);
    apply(32'h40, 1, 32'h40, 1, 32'h300, 0, 32'h44, 0);
    lookup(32'h40);
    apply(32'h40, 1, 32'h40, 1, 32'h300, 1, 32'h300, 1);
    lookup(32'h40);
    lookup(32'h80);
    lookup(32'hFFFF_FFFC);

    for (int n = 0; n < 400; n++) begin
      upc  = rnd_pc();
      ut   = 1'($urandom_range(0, 1));
      utg  = 32'($urandom_range(0, 255)) << 2;
      upt  = ($urandom_range(0, 3) != 0) ? ut : ~ut;
      uptg = ($urandom_range(0, 3) != 0) ? utg : 32'($urandom_range(0, 255)) << 2;
      apply(rnd_pc(), 1'($urandom_range(0, 3) != 0), upc, ut, utg, upt, uptg,
            1'($urandom_range(0, 31) == 0));
    end

    // asynchronous reset mid-run clears table and counters at once
    apply(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
    #2;
    rst_i = 1;
    #1;
    model_reset();
    check_eq("arst_hit", 64'(bus.hit_o), 64'd0);
    check_eq("arst_upd_cnt", 64'(bus.upd_cnt_o), 64'd0);
    check_eq("arst_mis_cnt", 64'(bus.mispred_cnt_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 0;
    lookup(32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer (BTB) with 2-bit saturating direction counters, used by the IF stage of the 5-stage pipelined CPU.
- Lets IF fetch a predicted branch target instead of always fetching PC+4. Today branches resolve late and always cost a redirect.
- The branch-resolve stage feeds the actual outcome back. The block reports mispredicts and the corrected fetch PC.

Parameters:
ADDR_W, 32, PC/target width in bits.
ENTRIES, 16, BTB depth; power of 2, minimum 2.
IDX_W, log2(ENTRIES), derived localparam; index = pc[IDX_W+1:2].
TAG_W, ADDR_W-IDX_W-2, derived localparam; tag = pc[ADDR_W-1:IDX_W+2].

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-high.
lookup_pc_i  in  ADDR_W  IF-stage PC.
hit_o  out  1  valid entry with matching tag at lookup index.
predict_taken_o  out  1  predicted taken (hit_o AND counter MSB).
predict_target_o  out  ADDR_W  next fetch PC: entry target if predict_taken_o, else lookup_pc_i+4.
upd_valid_i  in  1  resolve-stage branch update strobe.
upd_pc_i  in  ADDR_W  PC of the resolved branch.
upd_taken_i  in  1  actual direction.
upd_target_i  in  ADDR_W  actual taken target.
upd_pred_taken_i  in  1  prediction originally made for this branch (piped down).
upd_pred_target_i  in  ADDR_W  predicted next PC originally made (piped down).
flush_i  in  1  synchronous invalidate of all entries.
mispredict_o  out  1  update disagrees with the original prediction.
redirect_pc_o  out  ADDR_W  corrected fetch PC.
upd_cnt_o  out  32  count of updates (optional feature).
mispred_cnt_o  out  32  count of mispredicts (optional feature).

Behaviour:
- Entry fields: valid, tag[TAG_W], target[ADDR_W], cnt[1:0].
- Reset (async, rst_i=1): all valid=0, all cnt=2'b01, all targets and tags=0.
- With every entry invalid, outputs settle to hit_o=0, predict_taken_o=0, predict_target_o=lookup_pc_i+4, mispredict_o=0 (when upd_valid_i=0), counters=0.
- Lookup: purely combinational, 0-cycle latency. Add+4 wraps modulo 2^ADDR_W.
- Update: takes effect at the rising edge when upd_valid_i=1. There is no write-to-read bypass, so a same-cycle lookup of the same index sees the old contents.
- Update on hit (valid and tag match):
  - taken: cnt saturating +1 (11 stays 11); target <= upd_target_i.
  - not taken: cnt saturating -1 (00 stays 00); target unchanged.
- Update on miss:
  - taken: allocate/replace at index; valid=1, tag, target=upd_target_i, cnt=2'b10.
  - not taken: no table change.
- Aliasing: same index with a different tag is a miss; a taken update overwrites the old entry (direct-mapped).
- mispredict_o (combinational) = upd_valid_i AND (upd_taken_i != upd_pred_taken_i OR (upd_taken_i AND upd_target_i != upd_pred_target_i)).
- redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4. It is meaningful only when mispredict_o=1.
- flush_i=1 at an edge: all valid=0 and cnt=01; an update in the same cycle is dropped (flush wins).
- rst_i asserted mid-operation: immediate async clear; no partial update is committed.

Optional Feature:
- Macro: BTB_PERF_CNT_EN.
- Defined:
  - upd_cnt_o increments on each edge with upd_valid_i=1 and flush_i=0.
  - mispred_cnt_o increments on each edge with mispredict_o=1 and flush_i=0.
  - Both saturate at 32'hFFFFFFFF, clear only on rst_i, and are not cleared by flush_i.
- Undefined: both ports driven constant 0; no counter flops synthesised.

Test Plan:
1. Reset, then lookup 0x40 -> hit_o=0, predict_taken_o=0, predict_target_o=0x44.
2. Update pc=0x40, taken=1, target=0x100, pred_taken=0 -> mispredict_o=1, redirect_pc_o=0x100 that cycle. Next cycle lookup 0x40 -> hit=1, taken=1, target=0x100.
3. From case 2 (cnt=10), three not-taken updates at 0x40 -> cnt 01, 00, 00. Lookup gives taken=0, target=0x44. One taken update -> cnt=01, still predict not-taken.
4. Alias (ENTRIES=16): 0x40 allocated; lookup 0x80 -> hit=0. Taken update 0x80 target 0x200 -> lookup 0x80 hit=1 target=0x200; lookup 0x40 hit=0.
5. Same cycle: update 0x40 taken plus lookup 0x40 -> outputs show pre-update state. Separately, flush_i=1 with upd_valid_i=1 -> next cycle every lookup hit=0.
6. BTB_PERF_CNT_EN defined: 5 updates, 2 mispredicting -> upd_cnt_o=5, mispred_cnt_o=2. Assert rst_i mid-run -> both 0 immediately.
